// File: rtl/uart_tx_framed_pkg.sv
// Shared definitions for the framed UART transmitter: FSM encoding, bit timing
// constants and the parity helper.
package uart_tx_framed_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } txState_t;

    localparam int BIT_STROBES = 16;
    localparam int DATA_BITS   = 8;

    function automatic logic parityOf(input logic [DATA_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_tx_framed_fifo.sv
// Byte FIFO feeding the transmitter; the head byte is presented on a registered
// output so the shifter can load it in the same cycle it pops.
module uart_tx_fifo
    import uart_tx_framed_pkg::*;
#(
    parameter int LOG2_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 push,
    input  logic                 pop,
    input  logic [DATA_BITS-1:0] din,
    output logic [DATA_BITS-1:0] dout,
    output logic                 empty,
    output logic                 halfFull,
    output logic                 full
);

    localparam int DEPTH = 2 ** LOG2_DEPTH;
    localparam logic [LOG2_DEPTH:0] FULL_COUNT = {1'b1, {LOG2_DEPTH{1'b0}}};
    localparam logic [LOG2_DEPTH:0] HALF_COUNT = FULL_COUNT >> 1;

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [DATA_BITS-1:0]  doutReg;
    logic [LOG2_DEPTH-1:0] wrPtrReg;
    logic [LOG2_DEPTH-1:0] rdPtrReg;
    logic [LOG2_DEPTH-1:0] rdPtrNext;
    logic [LOG2_DEPTH:0]   countReg;
    logic                  pushOk;
    logic                  popOk;

    assign pushOk    = push && !full;
    assign popOk     = pop && !empty;
    assign rdPtrNext = popOk ? rdPtrReg + 1'b1 : rdPtrReg;

    assign empty    = (countReg == '0);
    assign full     = (countReg == FULL_COUNT);
    assign halfFull = (countReg >= HALF_COUNT);
    assign dout     = doutReg;

    // A byte written into the slot that becomes the head must bypass the array,
    // otherwise the registered read would return the stale slot contents.
    always_ff @(posedge clk) begin
        if (pushOk) begin
            mem[wrPtrReg] <= din;
        end
        if (pushOk && (wrPtrReg == rdPtrNext)) begin
            doutReg <= din;
        end else begin
            doutReg <= mem[rdPtrNext];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wrPtrReg <= '0;
            rdPtrReg <= '0;
            countReg <= '0;
        end else begin
            rdPtrReg <= rdPtrNext;
            if (pushOk) begin
                wrPtrReg <= wrPtrReg + 1'b1;
            end
            case ({pushOk, popOk})
                2'b10:   countReg <= countReg + 1'b1;
                2'b01:   countReg <= countReg - 1'b1;
                default: countReg <= countReg;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_framed.sv
// Buffered UART transmitter: FIFO-fed, LSB-first, optional parity, 1 or 2 stop
// bits, paced by a x16 baud strobe and gated by cts at each frame start.
module uart_tx_framed
    import uart_tx_framed_pkg::*;
#(
    parameter int LOG2_DEPTH = 4,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 x16BaudStrobe,
    input  logic [DATA_BITS-1:0] dataIn,
    input  logic                 write,
    input  logic                 cts,
    output logic                 serialOut,
    output logic                 dataPresent,
    output logic                 halfFull,
    output logic                 full,
    output logic                 busy,
    output logic                 overflow
);

    txState_t             stateReg, stateNext;
    logic [3:0]           subCountReg, subCountNext;
    logic [2:0]           bitIdxReg, bitIdxNext;
    logic                 stopIdxReg, stopIdxNext;
    logic [DATA_BITS-1:0] shiftReg, shiftNext;
    logic                 parityReg, parityNext;
    logic                 serialReg, serialNext;
    logic                 overflowReg;

    logic [DATA_BITS-1:0] fifoDout;
    logic                 fifoEmpty;
    logic                 fifoPush;
    logic                 fifoPop;
    logic                 bitEnd;
    logic                 lastStop;
    logic                 startFrame;

    assign fifoPush = write && !full;

    uart_tx_fifo #(
        .LOG2_DEPTH(LOG2_DEPTH)
    ) fifoInst (
        .clk     (clk),
        .rst     (rst),
        .push    (fifoPush),
        .pop     (fifoPop),
        .din     (dataIn),
        .dout    (fifoDout),
        .empty   (fifoEmpty),
        .halfFull(halfFull),
        .full    (full)
    );

    assign dataPresent = !fifoEmpty;
    assign startFrame  = dataPresent && cts;
    assign bitEnd      = (subCountReg == 4'(BIT_STROBES - 1));
    assign lastStop    = (STOP_BITS == 1) || stopIdxReg;
    assign serialOut   = serialReg;
    assign busy        = (stateReg != IDLE);
    assign overflow    = overflowReg;

    always_comb begin
        stateNext    = stateReg;
        subCountNext = subCountReg;
        bitIdxNext   = bitIdxReg;
        stopIdxNext  = stopIdxReg;
        shiftNext    = shiftReg;
        parityNext   = parityReg;
        serialNext   = serialReg;
        fifoPop      = 1'b0;

        if (x16BaudStrobe) begin
            subCountNext = subCountReg + 1'b1;
            case (stateReg)
                IDLE: begin
                    subCountNext = '0;
                    serialNext   = 1'b1;
                    if (startFrame) begin
                        fifoPop    = 1'b1;
                        shiftNext  = fifoDout;
                        parityNext = parityOf(fifoDout, PARITY_ODD != 0);
                        stateNext  = START;
                        serialNext = 1'b0;
                    end
                end
                START: begin
                    if (bitEnd) begin
                        stateNext  = DATA;
                        bitIdxNext = '0;
                        serialNext = shiftReg[0];
                    end
                end
                DATA: begin
                    if (bitEnd) begin
                        if (bitIdxReg == 3'(DATA_BITS - 1)) begin
                            if (PARITY_EN != 0) begin
                                stateNext  = PARITY;
                                serialNext = parityReg;
                            end else begin
                                stateNext   = STOP;
                                stopIdxNext = 1'b0;
                                serialNext  = 1'b1;
                            end
                        end else begin
                            bitIdxNext = bitIdxReg + 1'b1;
                            shiftNext  = shiftReg >> 1;
                            serialNext = shiftReg[1];
                        end
                    end
                end
                PARITY: begin
                    if (bitEnd) begin
                        stateNext   = STOP;
                        stopIdxNext = 1'b0;
                        serialNext  = 1'b1;
                    end
                end
                STOP: begin
                    if (bitEnd) begin
                        if (!lastStop) begin
                            stopIdxNext = 1'b1;
                        end else if (startFrame) begin
                            // Chain straight into the next start bit: no idle gap.
                            fifoPop    = 1'b1;
                            shiftNext  = fifoDout;
                            parityNext = parityOf(fifoDout, PARITY_ODD != 0);
                            stateNext  = START;
                            serialNext = 1'b0;
                        end else begin
                            stateNext  = IDLE;
                            serialNext = 1'b1;
                        end
                    end
                end
                default: begin
                    stateNext  = IDLE;
                    serialNext = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateReg    <= IDLE;
            subCountReg <= '0;
            bitIdxReg   <= '0;
            stopIdxReg  <= 1'b0;
            shiftReg    <= '0;
            parityReg   <= 1'b0;
            serialReg   <= 1'b1;
            overflowReg <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            subCountReg <= subCountNext;
            bitIdxReg   <= bitIdxNext;
            stopIdxReg  <= stopIdxNext;
            shiftReg    <= shiftNext;
            parityReg   <= parityNext;
            serialReg   <= serialNext;
            overflowReg <= overflowReg | (write & full);
        end
    end

endmodule

// File: tb/tb_uart_tx_framed.sv
// Directed bench for uart_tx_framed: a default instance and a parity/2-stop
// instance, frames sampled mid-bit with a strobe every 8 clk (128 clk per bit).
module tb_uart_tx_framed;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       strobe = 1'b0;
    logic [2:0] sdiv = '0;
    logic [7:0] dataIn = '0;
    logic       write0 = 1'b0;
    logic       write1 = 1'b0;
    logic       cts = 1'b0;

    logic serialOut0, dataPresent0, halfFull0, full0, busy0, overflow0;
    logic serialOut1, dataPresent1, halfFull1, full1, busy1, overflow1;

    logic sel = 1'b0;
    logic lineMon;
    logic busyMon;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        which;
        logic [7:0]  data;
        int          nbits;
        logic [11:0] expBits;
    } vec_t;

    vec_t vecs[5];

    uart_tx_framed dut0 (
        .clk          (clk),
        .rst          (rst),
        .x16BaudStrobe(strobe),
        .dataIn       (dataIn),
        .write        (write0),
        .cts          (cts),
        .serialOut    (serialOut0),
        .dataPresent  (dataPresent0),
        .halfFull     (halfFull0),
        .full         (full0),
        .busy         (busy0),
        .overflow     (overflow0)
    );

    uart_tx_framed #(
        .LOG2_DEPTH(4),
        .PARITY_EN (1),
        .PARITY_ODD(0),
        .STOP_BITS (2)
    ) dut1 (
        .clk          (clk),
        .rst          (rst),
        .x16BaudStrobe(strobe),
        .dataIn       (dataIn),
        .write        (write1),
        .cts          (cts),
        .serialOut    (serialOut1),
        .dataPresent  (dataPresent1),
        .halfFull     (halfFull1),
        .full         (full1),
        .busy         (busy1),
        .overflow     (overflow1)
    );

    assign lineMon = sel ? serialOut1 : serialOut0;
    assign busyMon = sel ? busy1 : busy0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        sdiv   <= sdiv + 3'd1;
        strobe <= (sdiv == 3'd7);
    end

    initial begin
        repeat (150000) @(posedge clk);
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end else begin
            $display("pass %s value=0x%0h", name, act);
        end
    endtask

    task automatic writeByte(input logic which, input logic [7:0] d);
        @(negedge clk);
        dataIn = d;
        if (which) write1 = 1'b1;
        else       write0 = 1'b1;
        @(negedge clk);
        write0 = 1'b0;
        write1 = 1'b0;
    endtask

    // Waits for the start edge, then samples nbits bit centres.
    task automatic captureFrame(input logic which, input int nbits, input bit dropCts,
                                output logic [11:0] bits, output int waited);
        sel    = which;
        bits   = '0;
        waited = 0;
        do begin
            @(negedge clk);
            waited++;
        end while (lineMon !== 1'b0 && waited < 4000);
        check("start_edge_seen", {31'd0, (waited < 4000)}, 32'd1);
        if (dropCts) cts = 1'b0;
        repeat (64) @(negedge clk);
        bits[0] = lineMon;
        for (int i = 1; i < nbits; i++) begin
            repeat (128) @(negedge clk);
            bits[i] = lineMon;
        end
    endtask

    initial begin
        logic [11:0] bits;
        int          waited;
        int          lowSeen;

        vecs[0] = '{1'b0, 8'hA5, 10, 12'b00_1101001010};
        vecs[1] = '{1'b0, 8'h00, 10, 12'b00_1000000000};
        vecs[2] = '{1'b0, 8'hFF, 10, 12'b00_1111111110};
        vecs[3] = '{1'b1, 8'h07, 12, 12'b111000001110};
        vecs[4] = '{1'b1, 8'h03, 12, 12'b110000000110};

        // Reset state
        repeat (4) @(negedge clk);
        check("rst_serialOut0", {31'd0, serialOut0}, 32'd1);
        check("rst_flags0", {27'd0, dataPresent0, halfFull0, full0, busy0, overflow0}, 32'd0);
        check("rst_serialOut1", {31'd0, serialOut1}, 32'd1);
        check("rst_flags1", {27'd0, dataPresent1, halfFull1, full1, busy1, overflow1}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cts = 1'b1;
        repeat (2) @(negedge clk);

        // Table-driven single frames
        for (int v = 0; v < 5; v++) begin
            writeByte(vecs[v].which, vecs[v].data);
            check($sformatf("v%0d_dataPresent", v),
                  {31'd0, vecs[v].which ? dataPresent1 : dataPresent0}, 32'd1);
            captureFrame(vecs[v].which, vecs[v].nbits, 1'b0, bits, waited);
            check($sformatf("v%0d_frame_bits", v), {20'd0, bits}, {20'd0, vecs[v].expBits});
            check($sformatf("v%0d_rx_byte", v), {24'd0, bits[8:1]}, {24'd0, vecs[v].data});
            repeat (56) @(negedge clk);
            check($sformatf("v%0d_busy_before_end", v), {31'd0, busyMon}, 32'd1);
            repeat (16) @(negedge clk);
            check($sformatf("v%0d_busy_after_end", v), {31'd0, busyMon}, 32'd0);
        end

        // Flow control: held off by cts, then a frame that survives cts dropping
        cts = 1'b0;
        writeByte(1'b0, 8'h3C);
        check("fc_dataPresent", {31'd0, dataPresent0}, 32'd1);
        lowSeen = 0;
        repeat (1000) begin
            @(negedge clk);
            if (serialOut0 !== 1'b1) lowSeen++;
        end
        check("fc_idle_while_cts_low", lowSeen, 32'd0);
        check("fc_not_busy", {31'd0, busy0}, 32'd0);
        cts = 1'b1;
        captureFrame(1'b0, 10, 1'b1, bits, waited);
        check("fc_start_latency", {31'd0, (waited <= 9)}, 32'd1);
        check("fc_frame_bits", {20'd0, bits}, {22'd0, 10'b1001111000});
        repeat (72) @(negedge clk);
        check("fc_idle_after", {31'd0, busy0}, 32'd0);

        // FIFO fill, overflow, back-to-back drain
        cts = 1'b0;
        for (int k = 0; k < 16; k++) begin
            writeByte(1'b0, 8'(k));
            check($sformatf("fill%0d_halfFull", k), {31'd0, halfFull0}, {31'd0, (k >= 7)});
            check($sformatf("fill%0d_full", k), {31'd0, full0}, {31'd0, (k == 15)});
        end
        check("pre_overflow", {31'd0, overflow0}, 32'd0);
        writeByte(1'b0, 8'hFF);
        check("overflow_set", {31'd0, overflow0}, 32'd1);
        check("full_after_drop", {31'd0, full0}, 32'd1);
        cts = 1'b1;
        for (int k = 0; k < 16; k++) begin
            captureFrame(1'b0, 10, 1'b0, bits, waited);
            check($sformatf("b2b%0d_frame", k), {20'd0, bits}, {22'd0, 1'b1, 8'(k), 1'b0});
            if (k == 0) check("b2b0_latency", {31'd0, (waited <= 9)}, 32'd1);
            else        check($sformatf("b2b%0d_no_gap", k), {31'd0, (waited <= 66)}, 32'd1);
        end
        check("overflow_sticky", {31'd0, overflow0}, 32'd1);
        repeat (80) @(negedge clk);
        check("drained_dataPresent", {31'd0, dataPresent0}, 32'd0);
        lowSeen = 0;
        repeat (300) begin
            @(negedge clk);
            if (serialOut0 !== 1'b1) lowSeen++;
        end
        check("dropped_byte_not_sent", lowSeen, 32'd0);

        // Reset mid-frame during data bit 3 of 0x55
        writeByte(1'b0, 8'h55);
        captureFrame(1'b0, 5, 1'b0, bits, waited);
        check("mid_partial_bits", {20'd0, bits}, 32'b01010);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_serialOut", {31'd0, serialOut0}, 32'd1);
        check("mid_rst_flags", {27'd0, dataPresent0, halfFull0, full0, busy0, overflow0}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        cts = 1'b1;
        writeByte(1'b0, 8'h81);
        captureFrame(1'b0, 10, 1'b0, bits, waited);
        check("post_rst_frame", {20'd0, bits}, {22'd0, 10'b1100000010});
        repeat (72) @(negedge clk);
        check("post_rst_idle", {31'd0, busy0}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
